// File: rtl/pwm_capture_if.sv
// Measurement bus of the PWM capture block: the raw PWM line in, the measurement and stuck status out.
// The capture block uses the master modport; the status/control consumer uses the slave modport.
interface pwm_capture_if #(
  parameter int W = 16
);
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         stuck;
  logic         stuck_level;

  modport master (
    input  pwm_in,
    output period, high_time, valid, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  period, high_time, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures the period and high time of an asynchronous PWM input, and flags an input that has stopped toggling.
// Latency: valid and data appear on the 3rd clock edge that samples pwm_in high after a low phase.
// No backpressure: valid is a one-cycle strobe and the consumer must capture it.
module pwm_capture #(
  parameter int W       = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk_in,
  input  logic          rst_n,
  pwm_capture_if.master bus
);
  typedef enum logic [1:0] {IDLE, ARMED_HI, LOW, RUN_HI} state_t;

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TO      = W'(TIMEOUT);

  state_t       state, state_nxt;
  logic         s1, s, s_d;
  logic [2:0]   prime;
  logic [W-1:0] cnt, hi, idle;
  logic         rise, fall, timeout_hit, publish;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
      prime <= 3'b000;
    end else begin
      s1    <= bus.pwm_in;
      s     <= s1;
      s_d   <= s;
      prime <= {prime[1:0], 1'b1};
    end
  end

  // Edges are ignored until s_d holds a real sample, so a line that is high at reset release does not look like a rise.
  assign rise        = prime[2] & s & ~s_d;
  assign fall        = prime[2] & ~s & s_d;
  assign timeout_hit = ~(rise | fall) & (idle == TO - 1'b1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hi   <= '0;
      idle <= '0;
    end else begin
      if (rise)
        cnt <= W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      if (fall)
        hi <= cnt;

      if (rise | fall)
        idle <= '0;
      else if (idle != TO)
        idle <= idle + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (rise) state_nxt = ARMED_HI;
        ARMED_HI: if (fall) state_nxt = LOW;
        LOW: begin
          if (rise) begin
            state_nxt = RUN_HI;
            publish   = 1'b1;
          end
        end
        RUN_HI:   if (fall) state_nxt = LOW;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bus.period      <= '0;
      bus.high_time   <= '0;
      bus.valid       <= 1'b0;
      bus.stuck       <= 1'b0;
      bus.stuck_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus.valid <= publish;
      if (publish) begin
        bus.period    <= cnt;
        bus.high_time <= hi;
      end
      if (rise | fall) begin
        bus.stuck <= 1'b0;
      end else if (timeout_hit) begin
        bus.stuck       <= 1'b1;
        bus.stuck_level <= s;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a scoreboard queue holds the measurements each PWM step should publish.
module tb_pwm_capture;
  localparam int W       = 16;
  localparam int TIMEOUT = 100;

  typedef struct packed {
    logic [W-1:0] period;
    logic [W-1:0] high;
  } meas_t;

  logic clk_in = 1'b0;
  logic rst_n;
  always #5 clk_in = ~clk_in;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  meas_t sb[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    prev_hi  = 0;
  int    prev_lo  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge clk_in);
      bus.pwm_in = v;
    end
  endtask

  task automatic expect_meas(input int per, input int hig);
    meas_t m;
    m.period = W'(per);
    m.high   = W'(hig);
    sb.push_back(m);
  endtask

  // One PWM period; when pub is set, its rising edge should publish the previous period.
  task automatic pwm_cycle(input int hi, input int lo, input bit pub);
    if (pub) expect_meas(prev_hi + prev_lo, prev_hi);
    drive(1'b1, hi);
    drive(1'b0, lo);
    prev_hi = hi;
    prev_lo = lo;
  endtask

  // Monitor: every valid strobe must match the oldest expected measurement.
  initial begin
    meas_t m;
    forever begin
      @(posedge clk_in);
      #1;
      if (bus.valid === 1'b1) begin
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_valid: observed valid with %0d queued, expected a queued entry", sb.size());
        end
        if (sb.size() != 0) begin
          m = sb.pop_front();
          check("period", 32'(bus.period), 32'(m.period));
          check("high_time", 32'(bus.high_time), 32'(m.high));
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    bus.pwm_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_period", 32'(bus.period), 0);
    check("rst_high_time", 32'(bus.high_time), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_stuck", 32'(bus.stuck), 0);
    check("rst_stuck_level", 32'(bus.stuck_level), 0);

    // Input held low from reset: stuck after exactly TIMEOUT cycles, level 0
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (TIMEOUT - 1) @(posedge clk_in);
    #1;
    check("low_stuck_early", 32'(bus.stuck), 0);
    @(posedge clk_in);
    #1;
    check("low_stuck", 32'(bus.stuck), 1);
    check("low_stuck_level", 32'(bus.stuck_level), 0);
    check("low_period_zero", 32'(bus.period), 0);

    // Steady period 20 / high 10
    pwm_cycle(10, 10, 1'b0);
    check("stuck_cleared", 32'(bus.stuck), 0);
    repeat (4) pwm_cycle(10, 10, 1'b1);
    check("steady_stuck", 32'(bus.stuck), 0);

    // High time steps 10 -> 11 with the period unchanged
    pwm_cycle(11, 9, 1'b1);
    pwm_cycle(11, 9, 1'b1);

    // Minimum pulse: high 1, period 2
    repeat (6) pwm_cycle(1, 1, 1'b1);

    // Hold high: stuck TIMEOUT cycles after the last synced edge, data held
    expect_meas(2, 1);
    drive(1'b1, 1);
    repeat (TIMEOUT + 2) @(posedge clk_in);
    #1;
    check("hi_stuck_early", 32'(bus.stuck), 0);
    @(posedge clk_in);
    #1;
    check("hi_stuck", 32'(bus.stuck), 1);
    check("hi_stuck_level", 32'(bus.stuck_level), 1);
    check("hi_period_hold", 32'(bus.period), 2);
    check("hi_high_hold", 32'(bus.high_time), 1);
    drive(1'b0, 4);
    @(posedge clk_in);
    #1;
    check("hi_stuck_cleared", 32'(bus.stuck), 0);
    drive(1'b0, 1);
    pwm_cycle(7, 8, 1'b0);
    pwm_cycle(7, 8, 1'b1);

    // Reset in the middle of a high phase
    pwm_cycle(6, 4, 1'b1);
    pwm_cycle(6, 4, 1'b1);
    expect_meas(10, 6);
    drive(1'b1, 3);
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    check("pre_reset_drained", 32'(sb.size()), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", 32'(bus.period), 0);
    check("mid_rst_high_time", 32'(bus.high_time), 0);
    check("mid_rst_valid", 32'(bus.valid), 0);
    check("mid_rst_stuck", 32'(bus.stuck), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 4);
    pwm_cycle(5, 5, 1'b0);
    pwm_cycle(5, 5, 1'b1);
    pwm_cycle(5, 5, 1'b1);
    expect_meas(10, 5);
    drive(1'b1, 2);
    drive(1'b0, 3);
    repeat (5) @(posedge clk_in);
    #1;
    check("final_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
